restart_sequencer: RTL

RESTART_SEQUENCER -- requirements
Module: restart_sequencer

---
 rtl/agc_alarm_pkg.sv | 27 ++
 rtl/alarm_prienc.sv | 19 +
 rtl/restart_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/agc_alarm_pkg.sv
// Shared definitions for the restart sequencer.
//   - FSM state encoding
//   - alarm bit positions within the 6-bit ALARM/ALMASK/CAUSE vectors
//   - FIRST_NONE, the "no cause" code reported on FIRST
package agc_alarm_pkg;

  localparam int NUM_ALM = 6;

  // Alarm bit positions (bit5 is the highest priority)
  localparam int ALM_PARITY  = 0;
  localparam int ALM_TCTRAP  = 1;
  localparam int ALM_RUPTLCK = 2;
  localparam int ALM_NIGHTW  = 3;
  localparam int ALM_VFAIL   = 4;
  localparam int ALM_OSCFAIL = 5;

  localparam logic [2:0]         FIRST_NONE = 3'd7;
  localparam logic [NUM_ALM-1:0] ALM_ALL    = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_JAM   = 2'd1,
    ST_START = 2'd2,
    ST_HOLD  = 2'd3
  } rs_state_t;

endpackage

// File: rtl/alarm_prienc.sv
// Priority encoder over the alarm vector.
//   req : 6-bit alarm edge vector
//   idx : index of the highest set bit (bit5 wins), FIRST_NONE when req==0
module alarm_prienc
  import agc_alarm_pkg::*;
(
  input  logic [NUM_ALM-1:0] req,
  output logic [2:0]         idx
);

  // Ascending scan: a later (higher) set bit overwrites a lower one.
  always_comb begin
    idx = FIRST_NONE;
    for (int i = 0; i < NUM_ALM; i++) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/restart_sequencer.sv
// Restart sequencer: turns rising alarm edges into a GOJAM / STRT1 restart
// sequence, followed by a HOLD dwell that lasts at least HOLD_MIN cycles and
// until every unmasked alarm has cleared. Logs sticky cause bits, the
// highest-priority cause of the latest restart and a saturating restart count.
//
// Ports
//   CLOCK   in   sole clock, rising edge
//   rst_    in   async reset, active low
//   ALARM   in   [5:0] alarm levels
//   ALMASK  in   [5:0] per-bit inhibit (1 = ignore)
//   ERRST   in   error-reset request (level)
//   GOJAM   out  restart jam pulse (JAM_CYC cycles)
//   STRT1   out  start pulse (STRT_CYC cycles) following GOJAM
//   BUSY    out  sequence in progress
//   CAUSE   out  [5:0] sticky cause bits
//   FIRST   out  [2:0] highest-priority cause of latest restart, 7 = none
//   RSTCNT  out  [3:0] saturating restart count
//   RESTRT  out  sticky restart lamp
//   AGCWAR  out  RSTCNT >= WARN_THR
module restart_sequencer
  import agc_alarm_pkg::*;
#(
  parameter int JAM_CYC  = 8,
  parameter int STRT_CYC = 4,
  parameter int HOLD_MIN = 16,
  parameter int WARN_THR = 3
) (
  input  logic       CLOCK,
  input  logic       rst_,
  input  logic [5:0] ALARM,
  input  logic [5:0] ALMASK,
  input  logic       ERRST,
  output logic       GOJAM,
  output logic       STRT1,
  output logic       BUSY,
  output logic [5:0] CAUSE,
  output logic [2:0] FIRST,
  output logic [3:0] RSTCNT,
  output logic       RESTRT,
  output logic       AGCWAR
);

  localparam logic [4:0] JAM_LD  = 5'(JAM_CYC - 1);
  localparam logic [4:0] STRT_LD = 5'(STRT_CYC - 1);
  localparam logic [4:0] HOLD_LD = 5'(HOLD_MIN - 1);
  localparam logic [3:0] WARN_L  = 4'(WARN_THR);

  rs_state_t           state, nstate;
  logic [4:0]          cnt, ncnt;
  logic [NUM_ALM-1:0]  as_q, as_nxt, edg_q;
  logic                start;
  logic [2:0]          first_idx;

  // ---------------------------------------------------------------------------
  // Alarm sampling. AS resets to all-ones so alarms already high when reset
  // releases are not seen as edges. The edge is registered, which gives the
  // one extra cycle from AS to GOJAM.
  // ---------------------------------------------------------------------------
  assign as_nxt = ALARM & ~ALMASK;

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      as_q  <= ALM_ALL;
      edg_q <= '0;
    end else begin
      as_q  <= as_nxt;
      edg_q <= as_nxt & ~as_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequence FSM
  // ---------------------------------------------------------------------------
  assign start = (state == ST_IDLE) && (|edg_q);

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    GOJAM  = 1'b0;
    STRT1  = 1'b0;
    BUSY   = 1'b1;
    unique case (state)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (start) begin
          nstate = ST_JAM;
          ncnt   = JAM_LD;
        end
      end
      ST_JAM: begin
        GOJAM = 1'b1;
        if (cnt == 5'd0) begin
          nstate = ST_START;
          ncnt   = STRT_LD;
        end else begin
          ncnt = cnt - 5'd1;
        end
      end
      ST_START: begin
        STRT1 = 1'b1;
        if (cnt == 5'd0) begin
          nstate = ST_HOLD;
          ncnt   = HOLD_LD;
        end else begin
          ncnt = cnt - 5'd1;
        end
      end
      ST_HOLD: begin
        // Minimum dwell, then wait for every unmasked alarm to clear.
        if (cnt != 5'd0) begin
          ncnt = cnt - 5'd1;
        end else if (as_q == '0) begin
          nstate = ST_IDLE;
        end
      end
      default: begin
        nstate = ST_IDLE;
        ncnt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Cause logging. ERRST clears, but a same-cycle edge or restart still lands.
  // ---------------------------------------------------------------------------
  alarm_prienc u_prienc (
    .req (edg_q),
    .idx (first_idx)
  );

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      CAUSE  <= '0;
      FIRST  <= FIRST_NONE;
      RSTCNT <= '0;
      RESTRT <= 1'b0;
    end else begin
      CAUSE <= (ERRST ? '0 : CAUSE) | edg_q;
      if (start) begin
        FIRST  <= first_idx;
        RESTRT <= 1'b1;
        if (ERRST)               RSTCNT <= 4'd1;
        else if (RSTCNT != 4'hF) RSTCNT <= RSTCNT + 4'd1;
      end else if (ERRST) begin
        FIRST  <= FIRST_NONE;
        RESTRT <= 1'b0;
        RSTCNT <= '0;
      end
    end
  end

  assign AGCWAR = (RSTCNT >= WARN_L);

endmodule
